// File: rtl/hazard_muldiv_ctrl.sv
// Hazard and M-extension sequencing control for the 5-stage RV32IM pipeline.
// Combinational stall/bubble/flush outputs; registered M-op FSM and stall-cycle counter.
module hazard_muldiv_ctrl #(
   parameter int MUL_CYCLES = 3,
   parameter int DIV_CYCLES = 34,
   parameter int CNT_W      = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1_addr_i,
   input  logic [4:0]  id_rs2_addr_i,
   input  logic        id_uses_rs1_i,
   input  logic        id_uses_rs2_i,
   input  logic        ex_mem_read_i,
   input  logic [4:0]  ex_rd_addr_i,
   input  logic        ex_redirect_i,
   input  logic        ex_is_muldiv_i,
   input  logic        ex_is_div_i,
   output logic        pc_stall_o,
   output logic        if_id_stall_o,
   output logic        if_id_flush_o,
   output logic        id_ex_bubble_o,
   output logic        id_ex_flush_o,
   output logic        id_ex_hold_o,
   output logic        ex_mem_bubble_o,
   output logic        muldiv_start_o,
   output logic        muldiv_done_o,
   output logic [31:0] stall_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // The start cycle and the DONE cycle are not counted, hence the -3.
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 3);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 3);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      stall_cnt_q, stall_cnt_d;

   logic m_start, m_busy, m_done, m_stall;
   logic load_use, lu_act;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      m_start = 1'b0;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ex_is_muldiv_i) begin
               m_start = 1'b1;
               cnt_d   = ex_is_div_i ? DIV_LOAD : MUL_LOAD;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            m_busy = 1'b1;
            if (cnt_q == '0) state_d = S_DONE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         // ex_is_muldiv_i still shows the finishing op here; never restart it.
         S_DONE: begin
            m_done  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      m_stall  = m_start | m_busy;
      load_use = ex_mem_read_i && (ex_rd_addr_i != 5'd0) &&
                 ((id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                  (id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i)));
      // During an M stall ID/EX holds; a bubble there would lose the ID instruction.
      lu_act   = load_use && !ex_redirect_i && !m_stall;

      pc_stall_o      = !rst && (m_stall || lu_act);
      if_id_stall_o   = !rst && (m_stall || lu_act);
      id_ex_bubble_o  = !rst && lu_act;
      if_id_flush_o   = !rst && ex_redirect_i;
      id_ex_flush_o   = !rst && ex_redirect_i;
      id_ex_hold_o    = !rst && m_stall;
      ex_mem_bubble_o = !rst && m_stall;
      muldiv_start_o  = !rst && m_start;
      muldiv_done_o   = !rst && m_done;

      stall_cnt_d = stall_cnt_q + (pc_stall_o ? 32'd1 : 32'd0);
   end

   assign stall_cnt_o = stall_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_muldiv_ctrl.sv
// Directed, table-driven bench for hazard_muldiv_ctrl (MUL_CYCLES=3, DIV_CYCLES=34).
module tb_hazard_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  id_rs1_addr_i = '0, id_rs2_addr_i = '0, ex_rd_addr_i = '0;
   logic        id_uses_rs1_i = 1'b0, id_uses_rs2_i = 1'b0, ex_mem_read_i = 1'b0;
   logic        ex_redirect_i = 1'b0, ex_is_muldiv_i = 1'b0, ex_is_div_i = 1'b0;
   logic        pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o, id_ex_flush_o;
   logic        id_ex_hold_o, ex_mem_bubble_o, muldiv_start_o, muldiv_done_o;
   logic [31:0] stall_cnt_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hazard_muldiv_ctrl #(.MUL_CYCLES(3), .DIV_CYCLES(34), .CNT_W(6)) dut (
      .clk(clk), .rst(rst),
      .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
      .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
      .ex_mem_read_i(ex_mem_read_i), .ex_rd_addr_i(ex_rd_addr_i),
      .ex_redirect_i(ex_redirect_i), .ex_is_muldiv_i(ex_is_muldiv_i),
      .ex_is_div_i(ex_is_div_i),
      .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o),
      .if_id_flush_o(if_id_flush_o), .id_ex_bubble_o(id_ex_bubble_o),
      .id_ex_flush_o(id_ex_flush_o), .id_ex_hold_o(id_ex_hold_o),
      .ex_mem_bubble_o(ex_mem_bubble_o), .muldiv_start_o(muldiv_start_o),
      .muldiv_done_o(muldiv_done_o), .stall_cnt_o(stall_cnt_o)
   );

   // Order: pc_stall, if_id_stall, if_id_flush, id_ex_bubble, id_ex_flush,
   //        id_ex_hold, ex_mem_bubble, start, done
   localparam logic [8:0] O_NONE  = 9'b000000000;
   localparam logic [8:0] O_LU    = 9'b110100000;
   localparam logic [8:0] O_FLUSH = 9'b001010000;
   localparam logic [8:0] O_MST   = 9'b110001110;
   localparam logic [8:0] O_MBUSY = 9'b110001100;
   localparam logic [8:0] O_MDONE = 9'b000000001;

   // A redirect while an M op is stalling EX is illegal stimulus.
   always @(posedge clk)
      if (!rst)
         assert (!(ex_redirect_i && id_ex_hold_o && !muldiv_start_o))
            else $error("protocol: redirect during M busy");

   function automatic logic [8:0] outs();
      return {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o, id_ex_flush_o,
              id_ex_hold_o, ex_mem_bubble_o, muldiv_start_o, muldiv_done_o};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_lu(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic mr, input logic [4:0] rd,
                         input logic redir);
      id_rs1_addr_i = rs1; id_rs2_addr_i = rs2;
      id_uses_rs1_i = u1;  id_uses_rs2_i = u2;
      ex_mem_read_i = mr;  ex_rd_addr_i  = rd;
      ex_redirect_i = redir;
   endtask

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, mr, redir;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[10];

   initial begin
      vecs[0] = '{rs1:5'd1,  rs2:5'd5, rd:5'd5,  u1:1, u2:1, mr:1, redir:0, exp:O_LU};
      vecs[1] = '{rs1:5'd0,  rs2:5'd0, rd:5'd0,  u1:1, u2:1, mr:1, redir:0, exp:O_NONE};
      vecs[2] = '{rs1:5'd1,  rs2:5'd5, rd:5'd5,  u1:1, u2:0, mr:1, redir:0, exp:O_NONE};
      vecs[3] = '{rs1:5'd5,  rs2:5'd2, rd:5'd5,  u1:1, u2:0, mr:1, redir:0, exp:O_LU};
      vecs[4] = '{rs1:5'd5,  rs2:5'd5, rd:5'd5,  u1:1, u2:1, mr:0, redir:0, exp:O_NONE};
      vecs[5] = '{rs1:5'd1,  rs2:5'd5, rd:5'd5,  u1:1, u2:1, mr:1, redir:1, exp:O_FLUSH};
      vecs[6] = '{rs1:5'd3,  rs2:5'd4, rd:5'd9,  u1:1, u2:1, mr:0, redir:1, exp:O_FLUSH};
      vecs[7] = '{rs1:5'd5,  rs2:5'd6, rd:5'd7,  u1:1, u2:1, mr:1, redir:0, exp:O_NONE};
      vecs[8] = '{rs1:5'd31, rs2:5'd0, rd:5'd31, u1:1, u2:0, mr:1, redir:0, exp:O_LU};
      vecs[9] = '{rs1:5'd5,  rs2:5'd6, rd:5'd5,  u1:0, u2:0, mr:1, redir:0, exp:O_NONE};

      // Reset: every hazard condition present, yet all outputs must be low.
      set_lu(5'd5, 5'd5, 1, 1, 1, 5'd5, 1);
      ex_is_muldiv_i = 1'b1;
      @(negedge clk); #1;
      check("reset_outs", 32'(outs()), 32'(O_NONE));
      check("reset_cnt", stall_cnt_o, 32'd0);
      ex_is_muldiv_i = 1'b0;
      set_lu(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // Single-cycle hazards from the table.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         set_lu(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].mr,
                vecs[i].rd, vecs[i].redir);
         #1;
         check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
      end
      @(negedge clk);
      set_lu(0, 0, 0, 0, 0, 0, 0);
      #1;
      check("cnt_after_table", stall_cnt_o, 32'd3);

      // MUL: start+stall, stall, done; load-use in ID is masked by the M stall.
      for (int c = 1; c <= 4; c++) begin
         if (c > 1) @(negedge clk);
         ex_is_muldiv_i = (c <= 3);
         ex_is_div_i    = 1'b0;
         set_lu(5'd5, 5'd0, 1, 0, c == 1, 5'd5, 0);
         if (c == 1) ex_mem_read_i = 1'b0;
         #1;
         check($sformatf("mul_c%0d", c), 32'(outs()),
               32'(c == 1 ? O_MST : c == 2 ? O_MBUSY : O_NONE | (c == 3 ? O_MDONE : O_NONE)));
      end
      set_lu(0, 0, 0, 0, 0, 0, 0);
      check("cnt_after_mul", stall_cnt_o, 32'd5);

      // DIV: 33 stall cycles, done in 34, back-to-back DIV starts in 35.
      ex_is_div_i = 1'b1;
      for (int c = 1; c <= 35; c++) begin
         @(negedge clk);
         ex_is_muldiv_i = 1'b1;
         #1;
         if (c == 1 || c == 35)      check($sformatf("div_c%0d", c), 32'(outs()), 32'(O_MST));
         else if (c == 34)           check("div_c34", 32'(outs()), 32'(O_MDONE));
         else if (c == 2 || c == 33) check($sformatf("div_c%0d", c), 32'(outs()), 32'(O_MBUSY));
         if (c == 34) check("cnt_after_div", stall_cnt_o, 32'd38);
      end

      // Second DIV: busy counter reaches 10 after 22 busy cycles; reset there.
      for (int c = 36; c <= 56; c++) @(negedge clk);
      @(negedge clk);
      #1;
      check("div2_busy_pre_rst", 32'(outs()), 32'(O_MBUSY));
      rst = 1'b1;
      #1;
      check("rst_mid_outs", 32'(outs()), 32'(O_NONE));
      check("rst_mid_cnt", stall_cnt_o, 32'd0);
      ex_is_muldiv_i = 1'b0;
      ex_is_div_i    = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         check($sformatf("post_rst_idle%0d", c), 32'(outs()), 32'(O_NONE));
      end
      check("post_rst_cnt", stall_cnt_o, 32'd0);

      // FSM must be back in IDLE: a new MUL starts at once.
      @(negedge clk);
      ex_is_muldiv_i = 1'b1;
      #1;
      check("post_rst_start", 32'(outs()), 32'(O_MST));
      @(negedge clk); @(negedge clk);
      #1;
      check("post_rst_done", 32'(outs()), 32'(O_MDONE));
      @(negedge clk);
      ex_is_muldiv_i = 1'b0;
      #1;
      check("cnt_post_mul2", stall_cnt_o, 32'd2);

      // Counter wrap.
      force dut.stall_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.stall_cnt_q;
      #1;
      check("cnt_preset", stall_cnt_o, 32'hFFFF_FFFF);
      set_lu(5'd7, 5'd0, 1, 0, 1, 5'd7, 0);
      #1;
      check("wrap_lu", 32'(outs()), 32'(O_LU));
      @(negedge clk);
      set_lu(0, 0, 0, 0, 0, 0, 0);
      #1;
      check("cnt_wrap", stall_cnt_o, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
